mull_writeback: RTL and testbench

//   Writeback sequencer directly downstream of the ALU. Takes Result/ResultExtra/ALUFlags
//   for one completed operation and drives a single-write-port register file. Long multiplies
//   (SMULL/UMULL) produce two destination words, so they are serialised over two write cycles

---
 rtl/mull_writeback_pkg.sv | 22 ++
 rtl/mull_writeback_nz.sv | 24 ++
 rtl/mull_writeback.sv | 121 ++++++++++++
 tb/tb_mull_writeback.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mull_writeback_pkg.sv
// rtl/mull_writeback_pkg.sv - shared ALU op codes, long-multiply helper and sequencer state type
//
// Purpose: constants and types shared by the writeback sequencer files.
//   ALU_MUL / ALU_SMULL / ALU_UMULL : ALUControl encodings seen at the writeback stage
//   alu_is_long(op)                 : 1 when op produces a two-word (64-bit) product
//   wb_state_t                      : sequencer state encoding (IDLE, HI)
package mull_writeback_pkg;

  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_SMULL = 3'b110;
  localparam logic [2:0] ALU_UMULL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } wb_state_t;

  function automatic logic alu_is_long(input logic [2:0] op);
    return (op == ALU_SMULL) || (op == ALU_UMULL);
  endfunction

endpackage

// File: rtl/mull_writeback_nz.sv
// rtl/mull_writeback_nz.sv - combinational N/Z flag generation over a 32- or 64-bit product
//
// Purpose: forms N and Z from the operation's full result width.
// Ports:
//   lo      in  DATA_W  low word / ordinary result
//   hi      in  DATA_W  high word (only meaningful when is_long)
//   is_long in  1       result is the 64-bit {hi, lo}
//   n       out 1       sign bit of the full result
//   z       out 1       full result is zero
module mul_nz_gen #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic              is_long,
  output logic              n,
  output logic              z
);

  assign n = is_long ? hi[DATA_W-1] : lo[DATA_W-1];
  // For short ops the high word is ignored entirely.
  assign z = (lo == '0) && (!is_long || (hi == '0));

endmodule

// File: rtl/mull_writeback.sv
// rtl/mull_writeback.sv - writeback sequencer serialising long multiplies onto one write port
//
// Purpose: takes one completed ALU operation per transfer and drives a single-write-port
//   register file. SMULL/UMULL write two words over two cycles (lo, then hi) with upstream
//   stalled; N/Z are issued alongside the last write of each operation.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready           transfer handshake (in_ready high only in IDLE)
//   ALUControl, Result, ResultExtra, rd_lo, rd_hi, set_flags : transferred operation
//   wr_en/wr_addr/wr_data       register-file write port (registered)
//   nz_we/n_flag/z_flag         N/Z flag update (registered)
//   pc_err                      pulse: a write to PC_ADDR was dropped
module mull_writeback
  import mull_writeback_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int PC_ADDR = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ALUControl,
  input  logic [DATA_W-1:0] Result,
  input  logic [DATA_W-1:0] ResultExtra,
  input  logic [ADDR_W-1:0] rd_lo,
  input  logic [ADDR_W-1:0] rd_hi,
  input  logic              set_flags,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              nz_we,
  output logic              n_flag,
  output logic              z_flag,
  output logic              pc_err
);

  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_ADDR);

  wb_state_t         state;
  logic [DATA_W-1:0] hi_q;
  logic [ADDR_W-1:0] rd_hi_q;
  // Flags of a long op are computed at transfer (full product visible then)
  // and replayed with the hi write.
  logic              n_hold;
  logic              z_hold;
  logic              s_hold;

  logic              is_long;
  logic              nz_n;
  logic              nz_z;

  assign in_ready = (state == IDLE);
  assign is_long  = alu_is_long(ALUControl);

  mul_nz_gen #(.DATA_W(DATA_W)) u_nz (
    .lo      (Result),
    .hi      (ResultExtra),
    .is_long (is_long),
    .n       (nz_n),
    .z       (nz_z)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      hi_q    <= '0;
      rd_hi_q <= '0;
      n_hold  <= 1'b0;
      z_hold  <= 1'b0;
      s_hold  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      nz_we   <= 1'b0;
      n_flag  <= 1'b0;
      z_flag  <= 1'b0;
      pc_err  <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      nz_we  <= 1'b0;
      pc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // PC destination: drop the write but keep address/data for visibility.
            wr_addr <= rd_lo;
            wr_data <= Result;
            wr_en   <= (rd_lo != PC_A);
            pc_err  <= (rd_lo == PC_A);
            if (is_long) begin
              hi_q    <= ResultExtra;
              rd_hi_q <= rd_hi;
              n_hold  <= nz_n;
              z_hold  <= nz_z;
              s_hold  <= set_flags;
              state   <= HI;
            end else begin
              nz_we  <= set_flags;
              n_flag <= nz_n;
              z_flag <= nz_z;
            end
          end
        end
        HI: begin
          wr_addr <= rd_hi_q;
          wr_data <= hi_q;
          wr_en   <= (rd_hi_q != PC_A);
          pc_err  <= (rd_hi_q == PC_A);
          nz_we   <= s_hold;
          n_flag  <= n_hold;
          z_flag  <= z_hold;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mull_writeback.sv
// tb/tb_mull_writeback.sv - table-driven and sequence checks for the writeback sequencer
module tb_mull_writeback;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] Result;
  logic [31:0] ResultExtra;
  logic [3:0]  rd_lo;
  logic [3:0]  rd_hi;
  logic        set_flags;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        nz_we;
  logic        n_flag;
  logic        z_flag;
  logic        pc_err;

  mull_writeback dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUControl  (ALUControl),
    .Result      (Result),
    .ResultExtra (ResultExtra),
    .rd_lo       (rd_lo),
    .rd_hi       (rd_hi),
    .set_flags   (set_flags),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .nz_we       (nz_we),
    .n_flag      (n_flag),
    .z_flag      (z_flag),
    .pc_err      (pc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        nz_we;
    logic        n;
    logic        z;
    logic        pc_err;
    logic        ready;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [31:0] res;
    logic [3:0]  lo;
    logic        s;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t mk(logic we, logic [3:0] a, logic [31:0] d, logic nzw,
                              logic n, logic z, logic pe, logic rdy);
    exp_t e;
    e.wr_en = we; e.addr = a; e.data = d; e.nz_we = nzw;
    e.n = n; e.z = z; e.pc_err = pe; e.ready = rdy;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                       input logic [31:0] ext, input logic [3:0] lo, input logic [3:0] hi,
                       input logic s);
    in_valid = v; ALUControl = op; Result = res; ResultExtra = ext;
    rd_lo = lo; rd_hi = hi; set_flags = s;
  endtask

  // Push expectation, clock once, pop and compare against the outputs now visible.
  task automatic cyc(input string tag, input exp_t e);
    exp_t x;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(x.wr_en));
    chk({tag, ".nz_we"}, 32'(nz_we), 32'(x.nz_we));
    chk({tag, ".pc_err"}, 32'(pc_err), 32'(x.pc_err));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(x.ready));
    if (x.wr_en) begin
      chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(x.addr));
      chk({tag, ".wr_data"}, wr_data, x.data);
    end
    if (x.nz_we) begin
      chk({tag, ".n_flag"}, 32'(n_flag), 32'(x.n));
      chk({tag, ".z_flag"}, 32'(z_flag), 32'(x.z));
    end
  endtask

  initial begin
    // Back-to-back single-cycle ops, applied on consecutive cycles.
    vecs[0] = '{1'b1, 3'b100, 32'hfffffffa, 4'd2, 1'b1, mk(1, 2, 32'hfffffffa, 1, 1, 0, 0, 1)};
    vecs[1] = '{1'b1, 3'b100, 32'h00000000, 4'd5, 1'b1, mk(1, 5, 32'h00000000, 1, 0, 1, 0, 1)};
    vecs[2] = '{1'b1, 3'b000, 32'h12345678, 4'd7, 1'b0, mk(1, 7, 32'h12345678, 0, 0, 0, 0, 1)};
    vecs[3] = '{1'b1, 3'b100, 32'h7fffffff, 4'd1, 1'b1, mk(1, 1, 32'h7fffffff, 1, 0, 0, 0, 1)};
    vecs[4] = '{1'b1, 3'b100, 32'h80000000, 4'd15, 1'b1, mk(0, 15, 32'h80000000, 1, 1, 0, 1, 1)};
    vecs[5] = '{1'b0, 3'b100, 32'hdeadbeef, 4'd6, 1'b1, mk(0, 0, 32'h0, 0, 0, 0, 0, 1)};
    vecs[6] = '{1'b1, 3'b101, 32'h00000001, 4'd0, 1'b1, mk(1, 0, 32'h00000001, 1, 0, 0, 0, 1)};

    reset = 1'b0;
    drive(1, 3'b110, 32'h1, 32'h2, 4'd3, 4'd4, 1);
    @(posedge clk); #1;
    cyc("reset", mk(0, 0, 32'h0, 0, 0, 0, 0, 1));
    chk("reset.wr_addr", 32'(wr_addr), 32'h0);
    chk("reset.wr_data", wr_data, 32'h0);
    chk("reset.n_flag", 32'(n_flag), 32'h0);
    chk("reset.z_flag", 32'(z_flag), 32'h0);
    reset = 1'b1;
    drive(0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 0);
    cyc("idle0", mk(0, 0, 32'h0, 0, 0, 0, 0, 1));

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].res, 32'hffff0000, vecs[i].lo, 4'd9, vecs[i].s);
      cyc($sformatf("vec%0d", i), vecs[i].e);
    end

    // SMULL -5*10
    drive(1, 3'b110, 32'hffffffce, 32'hffffffff, 4'd3, 4'd4, 1);
    cyc("smull.lo", mk(1, 3, 32'hffffffce, 0, 0, 0, 0, 0));
    drive(0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 0);
    cyc("smull.hi", mk(1, 4, 32'hffffffff, 1, 1, 0, 0, 1));

    // UMULL 10*45
    drive(1, 3'b111, 32'h000001c2, 32'h0, 4'd6, 4'd8, 1);
    cyc("umull.lo", mk(1, 6, 32'h000001c2, 0, 0, 0, 0, 0));
    drive(0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 0);
    cyc("umull.hi", mk(1, 8, 32'h0, 1, 0, 0, 0, 1));

    // UMULL 0*7: Z only on the second write
    drive(1, 3'b111, 32'h0, 32'h0, 4'd9, 4'd10, 1);
    cyc("umull0.lo", mk(1, 9, 32'h0, 0, 0, 0, 0, 0));
    drive(0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 0);
    cyc("umull0.hi", mk(1, 10, 32'h0, 1, 0, 1, 0, 1));

    // UMULL then a MUL held valid through the stall
    drive(1, 3'b111, 32'h5, 32'h1, 4'd1, 4'd2, 0);
    cyc("stall.lo", mk(1, 1, 32'h5, 0, 0, 0, 0, 0));
    drive(1, 3'b100, 32'h21, 32'h0, 4'd3, 4'd0, 1);
    cyc("stall.hi", mk(1, 2, 32'h1, 0, 0, 0, 0, 1));
    cyc("stall.mul", mk(1, 3, 32'h21, 1, 0, 0, 0, 1));
    drive(0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 0);
    cyc("stall.idle", mk(0, 0, 32'h0, 0, 0, 0, 0, 1));

    // High word aimed at PC
    drive(1, 3'b110, 32'h1, 32'h80000000, 4'd2, 4'd15, 1);
    cyc("pc.lo", mk(1, 2, 32'h1, 0, 0, 0, 0, 0));
    drive(0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 0);
    cyc("pc.hi", mk(0, 15, 32'h80000000, 1, 1, 0, 1, 1));
    cyc("pc.after", mk(0, 0, 32'h0, 0, 0, 0, 0, 1));

    // Same destination for both words: hi is written last
    drive(1, 3'b111, 32'h0000aaaa, 32'h0000bbbb, 4'd5, 4'd5, 0);
    cyc("same.lo", mk(1, 5, 32'h0000aaaa, 0, 0, 0, 0, 0));
    drive(0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 0);
    cyc("same.hi", mk(1, 5, 32'h0000bbbb, 0, 0, 0, 0, 1));

    // Reset while in HI discards the pending hi write
    drive(1, 3'b110, 32'h1, 32'h2, 4'd3, 4'd4, 1);
    cyc("rst.lo", mk(1, 3, 32'h1, 0, 0, 0, 0, 0));
    drive(0, 3'b000, 32'h0, 32'h0, 4'd0, 4'd0, 0);
    reset = 1'b0;
    cyc("rst.hold", mk(0, 0, 32'h0, 0, 0, 0, 0, 1));
    reset = 1'b1;
    cyc("rst.after1", mk(0, 0, 32'h0, 0, 0, 0, 0, 1));
    cyc("rst.after2", mk(0, 0, 32'h0, 0, 0, 0, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
